// File: rtl/add8_err_monitor.sv
// Error-characterisation stage for an 8-bit approximate adder: recomputes the exact
// sum per accepted sample and accumulates count, EP, MAE, MSE, WCE and HD numerators.
module add8_err_monitor #(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int SUM_W     = 32,
  parameter int SQ_W      = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       a_i,
  input  logic [7:0]       b_i,
  input  logic [8:0]       o_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] samples_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [SUM_W-1:0] sum_abs_o,
  output logic [SQ_W-1:0]  sum_sq_o,
  output logic [8:0]       wce_o,
  output logic [SUM_W-1:0] hd_sum_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             accept, flush, zero_acc;

  logic             vld_p1_q, vld_p2_q;
  logic [8:0]       exact_p1_q, appr_p1_q;
  logic signed [9:0] diff_d;
  logic [8:0]       abs_d;
  logic [17:0]      sq_d;
  logic [3:0]       hd_d;
  logic [8:0]       abs_p2_q;
  logic [17:0]      sq_p2_q;
  logic [3:0]       hd_p2_q;
  logic             ne_p2_q;

  logic [CNT_W-1:0] samples_q, err_cnt_q;
  logic [SUM_W-1:0] sum_abs_q, hd_sum_q;
  logic [SQ_W-1:0]  sum_sq_q;
  logic [8:0]       wce_q;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] acc, input logic inc);
    logic [CNT_W:0] s;
    s = {1'b0, acc} + {{CNT_W{1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0] acc, input logic [8:0] inc);
    logic [SUM_W+9:0] s;
    s = (SUM_W+10)'(acc) + (SUM_W+10)'(inc);
    return (s > (SUM_W+10)'({SUM_W{1'b1}})) ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  function automatic logic [SQ_W-1:0] sat_sq(input logic [SQ_W-1:0] acc, input logic [17:0] inc);
    logic [SQ_W+18:0] s;
    s = (SQ_W+19)'(acc) + (SQ_W+19)'(inc);
    return (s > (SQ_W+19)'({SQ_W{1'b1}})) ? {SQ_W{1'b1}} : s[SQ_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  // clear_i overrides everything, including start and acceptance on the same edge
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    accept    = 1'b0;
    flush     = 1'b0;
    zero_acc  = 1'b0;
    if (clear_i) begin
      state_d   = S_IDLE;
      acc_cnt_d = '0;
      flush     = 1'b1;
      zero_acc  = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d   = S_RUN;
            acc_cnt_d = '0;
            flush     = 1'b1;
            zero_acc  = 1'b1;
          end
        end
        S_RUN: begin
          if (in_valid_i) begin
            accept    = 1'b1;
            acc_cnt_d = acc_cnt_q + 1'b1;
            if (acc_cnt_d == N_LAST) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!vld_p1_q && !vld_p2_q) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign in_ready_o = (state_q == S_RUN);
  assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q & ~flush;
    end
  end

  assign diff_d = $signed({1'b0, exact_p1_q}) - $signed({1'b0, appr_p1_q});
  assign abs_d  = diff_d[9] ? 9'(-diff_d) : diff_d[8:0];
  assign sq_d   = abs_d * abs_d;
  assign hd_d   = 4'($countones(exact_p1_q ^ appr_p1_q));

  // Stage 1 captures the exact sum; stage 2 the per-sample error terms
  always_ff @(posedge clk) begin
    if (accept) begin
      exact_p1_q <= {1'b0, a_i} + {1'b0, b_i};
      appr_p1_q  <= o_i;
    end
    if (vld_p1_q) begin
      abs_p2_q <= abs_d;
      sq_p2_q  <= sq_d;
      hd_p2_q  <= hd_d;
      ne_p2_q  <= (abs_d != 9'd0);
    end
  end

  // Stage 3: saturating accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples_q <= '0;
      err_cnt_q <= '0;
      sum_abs_q <= '0;
      sum_sq_q  <= '0;
      wce_q     <= '0;
      hd_sum_q  <= '0;
    end else if (zero_acc) begin
      samples_q <= '0;
      err_cnt_q <= '0;
      sum_abs_q <= '0;
      sum_sq_q  <= '0;
      wce_q     <= '0;
      hd_sum_q  <= '0;
    end else if (vld_p2_q) begin
      samples_q <= sat_cnt(samples_q, 1'b1);
      err_cnt_q <= sat_cnt(err_cnt_q, ne_p2_q);
      sum_abs_q <= sat_sum(sum_abs_q, abs_p2_q);
      sum_sq_q  <= sat_sq(sum_sq_q, sq_p2_q);
      hd_sum_q  <= sat_sum(hd_sum_q, {5'd0, hd_p2_q});
      if (abs_p2_q > wce_q) wce_q <= abs_p2_q;
    end
  end

  assign samples_o = samples_q;
  assign err_cnt_o = err_cnt_q;
  assign sum_abs_o = sum_abs_q;
  assign sum_sq_o  = sum_sq_q;
  assign wce_o     = wce_q;
  assign hd_sum_o  = hd_sum_q;

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor: a reference model pushes expected metric
// snapshots at acceptance and they are compared two edges later.
module tb_add8_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, start_s = 1'b0, clear_i = 1'b0, in_valid_i = 1'b0;
  logic [7:0]  a_i = '0, b_i = '0;
  logic [8:0]  o_i = '0;

  logic        in_ready_o, busy_o, done_o;
  logic [16:0] samples_o, err_cnt_o;
  logic [31:0] sum_abs_o, hd_sum_o;
  logic [39:0] sum_sq_o;
  logic [8:0]  wce_o;

  logic        rdy_s, busy_s, done_s;
  logic [16:0] samples_s, err_s;
  logic [7:0]  abs_s, hd_s;
  logic [39:0] sq_s;
  logic [8:0]  wce_s;

  add8_err_monitor #(.N_SAMPLES(4), .CNT_W(17), .SUM_W(32), .SQ_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .a_i(a_i), .b_i(b_i), .o_i(o_i),
    .busy_o(busy_o), .done_o(done_o), .samples_o(samples_o), .err_cnt_o(err_cnt_o),
    .sum_abs_o(sum_abs_o), .sum_sq_o(sum_sq_o), .wce_o(wce_o), .hd_sum_o(hd_sum_o)
  );

  add8_err_monitor #(.N_SAMPLES(3), .CNT_W(17), .SUM_W(8), .SQ_W(40)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(start_s), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(rdy_s), .a_i(a_i), .b_i(b_i), .o_i(o_i),
    .busy_o(busy_s), .done_o(done_s), .samples_o(samples_s), .err_cnt_o(err_s),
    .sum_abs_o(abs_s), .sum_sq_o(sq_s), .wce_o(wce_s), .hd_sum_o(hd_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s, e, sa, sq, w, h;
  } snap_t;

  snap_t  q[$];
  bit     sb0 = 1'b0, sb1 = 1'b0;
  int     checks = 0, failures = 0;
  longint m_s, m_e, m_sa, m_sq, m_w, m_h;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_s = 0; m_e = 0; m_sa = 0; m_sq = 0; m_w = 0; m_h = 0;
  endtask

  // One active edge; a sample accepted two edges ago must now be visible
  task automatic edge_step();
    bit   due;
    snap_t sn;
    @(posedge clk);
    #1;
    due = sb1;
    sb1 = sb0;
    sb0 = 1'b0;
    if (due) begin
      sn = q.pop_front();
      chk("samples", 64'(samples_o), sn.s);
      chk("err_cnt", 64'(err_cnt_o), sn.e);
      chk("sum_abs", 64'(sum_abs_o), sn.sa);
      chk("sum_sq",  64'(sum_sq_o),  sn.sq);
      chk("wce",     64'(wce_o),     sn.w);
      chk("hd_sum",  64'(hd_sum_o),  sn.h);
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
    bit         acc;
    logic [8:0] ex;
    int         d, ab;
    snap_t      sn;
    in_valid_i = v; a_i = a; b_i = b; o_i = o;
    acc = v && in_ready_o;
    if (acc) begin
      ex = {1'b0, a} + {1'b0, b};
      d  = int'(ex) - int'(o);
      ab = (d < 0) ? -d : d;
      m_s++;
      if (ab != 0) m_e++;
      m_sa += ab;
      m_sq += longint'(ab) * ab;
      if (ab > m_w) m_w = ab;
      m_h += $countones(ex ^ o);
      sn.s = 64'(m_s); sn.e = 64'(m_e); sn.sa = 64'(m_sa);
      sn.sq = 64'(m_sq); sn.w = 64'(m_w); sn.h = 64'(m_h);
      q.push_back(sn);
    end
    edge_step();
    sb0 = acc;
    in_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    edge_step();
    start_i = 1'b0;
    model_zero();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_samples"}, 64'(samples_o), 0);
    chk({tag, "_err"},     64'(err_cnt_o), 0);
    chk({tag, "_abs"},     64'(sum_abs_o), 0);
    chk({tag, "_sq"},      64'(sum_sq_o),  0);
    chk({tag, "_wce"},     64'(wce_o),     0);
    chk({tag, "_hd"},      64'(hd_sum_o),  0);
  endtask

  bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [7:0] ra, rb;

  initial begin
    model_zero();
    // Reset state
    #12;
    check_zero("rst");
    chk("rst_ready", 64'(in_ready_o), 0);
    chk("rst_busy",  64'(busy_o), 0);
    chk("rst_done",  64'(done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // IDLE ignores samples
    cycle(1, 8'd5, 8'd5, 9'd0);
    chk("idle_ready", 64'(in_ready_o), 0);
    chk("idle_samples", 64'(samples_o), 0);

    // Run 1: spec example values, then completion timing
    pulse_start();
    chk("run_ready", 64'(in_ready_o), 1);
    chk("run_busy",  64'(busy_o), 1);
    cycle(1, 8'd3, 8'd4, 9'd6);
    cycle(1, 8'd255, 8'd255, 9'd0);
    cycle(0, 8'd0, 8'd0, 9'd0);
    cycle(0, 8'd0, 8'd0, 9'd0);
    chk("ex_samples", 64'(samples_o), 2);
    chk("ex_err",     64'(err_cnt_o), 2);
    chk("ex_abs",     64'(sum_abs_o), 511);
    chk("ex_sq",      64'(sum_sq_o),  260101);
    chk("ex_wce",     64'(wce_o),     510);
    chk("ex_hd",      64'(hd_sum_o),  9);
    cycle(1, 8'd10, 8'd20, 9'd30);
    cycle(1, 8'd100, 8'd27, 9'd120);
    chk("last_ready", 64'(in_ready_o), 0);
    chk("last_busy",  64'(busy_o), 1);
    cycle(0, 8'd0, 8'd0, 9'd0);
    cycle(0, 8'd0, 8'd0, 9'd0);
    chk("e2_busy", 64'(busy_o), 1);
    chk("e2_done", 64'(done_o), 0);
    cycle(0, 8'd0, 8'd0, 9'd0);
    chk("e3_done", 64'(done_o), 1);
    chk("e3_busy", 64'(busy_o), 0);
    cycle(1, 8'd9, 8'd9, 9'd0);
    chk("done_hold_samples", 64'(samples_o), 4);
    chk("done_hold_abs", 64'(sum_abs_o), 64'(m_sa));

    // Run 2: stalls, latency of first sample, backpressure after the 4th
    pulse_start();
    check_zero("restart");
    for (int i = 0; i < 7; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i == 0) cycle(1, 8'd1, 8'd1, 9'd0);
      else        cycle(pat[i], ra, rb, 9'($urandom_range(0, 511)));
      if (i == 1) chk("lat_e1_abs", 64'(sum_abs_o), 0);
    end
    chk("bp_ready_low", 64'(in_ready_o), 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'd77, 8'd1, 9'd0);
    chk("bp_samples", 64'(samples_o), 4);
    chk("bp_done", 64'(done_o), 1);
    chk("bp_sb_empty", 64'(q.size()), 0);

    // Run 3: exact adder produces no error
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      cycle(1, ra, rb, {1'b0, ra} + {1'b0, rb});
    end
    for (int i = 0; i < 3; i++) cycle(0, 8'd0, 8'd0, 9'd0);
    chk("exact_samples", 64'(samples_o), 4);
    chk("exact_err", 64'(err_cnt_o), 0);
    chk("exact_abs", 64'(sum_abs_o), 0);
    chk("exact_hd",  64'(hd_sum_o), 0);
    chk("exact_done", 64'(done_o), 1);

    // Run 4: clear with two samples in flight and an acceptance on the same edge
    pulse_start();
    cycle(1, 8'd200, 8'd10, 9'd0);
    cycle(1, 8'd100, 8'd100, 9'd1);
    clear_i = 1'b1; in_valid_i = 1'b1; a_i = 8'd50; b_i = 8'd50; o_i = 9'd0;
    @(posedge clk);
    #1;
    clear_i = 1'b0; in_valid_i = 1'b0;
    q.delete(); sb0 = 1'b0; sb1 = 1'b0; model_zero();
    chk("clr_busy",  64'(busy_o), 0);
    chk("clr_ready", 64'(in_ready_o), 0);
    chk("clr_done",  64'(done_o), 0);
    check_zero("clr");
    for (int i = 0; i < 3; i++) cycle(0, 8'd0, 8'd0, 9'd0);
    check_zero("clr_late");
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      cycle(1, ra, rb, 9'($urandom_range(0, 511)));
    end
    for (int i = 0; i < 3; i++) cycle(0, 8'd0, 8'd0, 9'd0);
    chk("post_clr_done", 64'(done_o), 1);
    chk("post_clr_sb_empty", 64'(q.size()), 0);

    // Saturation on an 8-bit sum instance: three samples of |err| = 200
    start_s = 1'b1;
    edge_step();
    start_s = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1, 8'd200, 8'd0, 9'd0);
    for (int i = 0; i < 4; i++) cycle(0, 8'd0, 8'd0, 9'd0);
    chk("sat_done",    64'(done_s), 1);
    chk("sat_samples", 64'(samples_s), 3);
    chk("sat_err",     64'(err_s), 3);
    chk("sat_abs",     64'(abs_s), 255);
    chk("sat_hd",      64'(hd_s), 9);
    chk("sat_sq",      64'(sq_s), 120000);
    chk("sat_wce",     64'(wce_s), 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
